// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I-side) and load/store (D-side).
// One transaction in flight at a time; data side wins ties unless fetch has been starved.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_req_i,
  input  logic [DATA_WIDTH-1:0] i_addr_i,
  input  logic                  i_kill_i,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  i_done_o,

  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic [3:0]            d_be_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_done_o,

  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  output logic                  stall_i_o,
  output logic                  stall_d_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [3:0]            starve_q, starve_d;
  logic                  kill_q, kill_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic i_cand;
  logic i_force;
  logic kill_now;

  // A fetch cancelled this cycle is never a candidate for arbitration.
  assign i_cand   = i_req_i & ~i_kill_i;
  assign i_force  = i_cand & (starve_q == StarveMax);
  assign kill_now = kill_q | ((owner_q == OwnI) & i_kill_i);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    kill_d    = kill_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        kill_d  = 1'b0;
        owner_d = OwnNone;
        if (d_req_i && !i_force) begin
          owner_d = OwnD;
          we_d    = d_we_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          be_d    = d_we_i ? d_be_i : 4'hF;
          state_d = StReq;
          if (i_req_i && (starve_q != StarveMax)) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (i_cand) begin
          owner_d  = OwnI;
          we_d     = 1'b0;
          addr_d   = i_addr_i;
          wdata_d  = '0;
          be_d     = 4'hF;
          state_d  = StReq;
          starve_d = 4'd0;
        end
      end

      StReq: begin
        if ((owner_q == OwnI) && i_kill_i) begin
          kill_d = 1'b1;
        end
        if (mem_gnt_i) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if ((owner_q == OwnI) && i_kill_i) begin
          kill_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          if (owner_q == OwnI) begin
            if (kill_now) begin
              // Killed fetch: the memory side completed, but the requester never hears of it.
              state_d = StIdle;
              owner_d = OwnNone;
              kill_d  = 1'b0;
            end else begin
              i_rdata_d = mem_rdata_i;
              state_d   = StDone;
            end
          end else begin
            d_rdata_d = mem_rdata_i;
            state_d   = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end

      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnNone;
      starve_q  <= 4'd0;
      kill_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= 4'h0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      kill_q    <= kill_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_req_o   = (state_q == StReq);
  assign mem_we_o    = (state_q == StReq) & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

  assign i_done_o  = (state_q == StDone) & (owner_q == OwnI);
  assign d_done_o  = (state_q == StDone) & (owner_q == OwnD);
  assign i_rdata_o = i_rdata_q;
  assign d_rdata_o = d_rdata_q;

  assign stall_i_o = i_req_i & ~i_done_o & ~i_kill_i;
  assign stall_d_o = d_req_i & ~d_done_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed protocol scenarios, then random traffic from both
// requesters against a memory model, checked by a queue scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_i, i_kill_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_rdata_o;
  logic        i_done_o;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_rdata_o;
  logic        d_done_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_i_o, stall_d_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_kill_i(i_kill_i),
    .i_rdata_o(i_rdata_o), .i_done_o(i_done_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_i_o(stall_i_o), .stall_d_o(stall_d_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected expected completion", name);
  endtask

  // Reference memory contents: unwritten words are a hash of their address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  typedef struct {
    bit          is_store;
    logic [31:0] data;
  } d_exp_t;

  logic [31:0] i_exp_q[$];
  d_exp_t      d_exp_q[$];
  bit          run_done;

  task automatic quiet_checks(input string tag);
    check1({tag, "_mem_req"}, mem_req_o, 1'b0);
    check1({tag, "_mem_we"}, mem_we_o, 1'b0);
    check32({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    check32({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    check32({tag, "_mem_be"}, {28'h0, mem_be_o}, 32'h0);
    check1({tag, "_i_done"}, i_done_o, 1'b0);
    check1({tag, "_d_done"}, d_done_o, 1'b0);
    check32({tag, "_i_rdata"}, i_rdata_o, 32'h0);
    check32({tag, "_d_rdata"}, d_rdata_o, 32'h0);
    check1({tag, "_stall_i"}, stall_i_o, 1'b0);
    check1({tag, "_stall_d"}, stall_d_o, 1'b0);
  endtask

  // Random fetch requester; occasionally cancels its request while waiting.
  task automatic i_driver(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      int          kill_at;
      int          cyc;
      bit          fin;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      i_exp_q.push_back(init_word(a));
      i_addr_i = a;
      i_req_i  = 1'b1;
      kill_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      cyc = 0;
      fin = 0;
      while (!fin) begin
        @(negedge clk);
        cyc++;
        if (i_done_o) begin
          fin = 1;
        end else if (cyc == kill_at) begin
          i_kill_i = 1'b1;
          void'(i_exp_q.pop_back());
          @(negedge clk);
          i_kill_i = 1'b0;
          fin = 1;
        end else if (cyc > 400) begin
          fail_now("i_timeout");
          void'(i_exp_q.pop_back());
          fin = 1;
        end
      end
      i_req_i = 1'b0;
    end
  endtask

  task automatic d_driver(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      d_exp_t      e;
      int          cyc;
      bit          fin;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      a         = 32'h2000 + 32'(4 * $urandom_range(0, 7));
      d_addr_i  = a;
      d_we_i    = ($urandom_range(0, 1) == 1);
      d_wdata_i = $urandom;
      d_be_i    = 4'($urandom_range(1, 15));
      e.is_store = d_we_i;
      if (d_we_i) begin
        e.data = 32'h0;
        ref_mem[a] = merge(ref_rd(a), d_wdata_i, d_be_i);
      end else begin
        e.data = ref_rd(a);
      end
      d_exp_q.push_back(e);
      d_req_i = 1'b1;
      cyc = 0;
      fin = 0;
      while (!fin) begin
        @(negedge clk);
        cyc++;
        if (d_done_o) begin
          fin = 1;
        end else if (cyc > 400) begin
          fail_now("d_timeout");
          void'(d_exp_q.pop_back());
          fin = 1;
        end
      end
      d_req_i = 1'b0;
    end
  endtask

  // Memory with random grant back-pressure and 1-3 cycle response delay.
  task automatic mem_model();
    bit          busy;
    int          cnt;
    logic [31:0] resp;
    busy = 0;
    cnt  = 0;
    resp = 32'h0;
    while (!run_done) begin
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      if (busy) begin
        if (cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = resp;
          busy         = 0;
        end else begin
          cnt--;
        end
      end else if (mem_req_o && mem_gnt_i) begin
        if (mem_we_o) begin
          dev_mem[mem_addr_o] = merge(dev_rd(mem_addr_o), mem_wdata_o, mem_be_o);
          resp = $urandom;
        end else begin
          check32("mem_be_read", {28'h0, mem_be_o}, 32'hF);
          resp = dev_rd(mem_addr_o);
        end
        busy = 1;
        cnt  = int'($urandom_range(0, 2));
      end
    end
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic monitor();
    d_exp_t e;
    while (!run_done) begin
      @(negedge clk);
      if (i_done_o && d_done_o) fail_now("dual_done");
      if (i_done_o) begin
        if (i_exp_q.size() == 0) fail_now("i_unexpected_done");
        else check32("i_rdata", i_rdata_o, i_exp_q.pop_front());
      end
      if (d_done_o) begin
        if (d_exp_q.size() == 0) begin
          fail_now("d_unexpected_done");
        end else begin
          e = d_exp_q.pop_front();
          if (!e.is_store) check32("d_rdata", d_rdata_o, e.data);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got[$];
    i_req_i = 0; i_kill_i = 0; i_addr_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_be_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    run_done = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 quiet_checks("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single fetch, immediate grant, response the cycle after grant.
    @(negedge clk);
    i_req_i = 1; i_addr_i = 32'h100; mem_gnt_i = 1;
    #1 check1("fetch_c0_stall", stall_i_o, 1'b1);
    check1("fetch_c0_memreq", mem_req_o, 1'b0);
    @(negedge clk);
    #1 check1("fetch_c1_memreq", mem_req_o, 1'b1);
    check32("fetch_c1_addr", mem_addr_o, 32'h100);
    check32("fetch_c1_be", {28'h0, mem_be_o}, 32'hF);
    check1("fetch_c1_we", mem_we_o, 1'b0);
    check1("fetch_c1_stall", stall_i_o, 1'b1);
    @(negedge clk);
    mem_rvalid_i = 1; mem_rdata_i = 32'h00500093;
    #1 check1("fetch_c2_memreq", mem_req_o, 1'b0);
    check1("fetch_c2_stall", stall_i_o, 1'b1);
    @(negedge clk);
    mem_rvalid_i = 0;
    #1 check1("fetch_c3_done", i_done_o, 1'b1);
    check32("fetch_c3_rdata", i_rdata_o, 32'h00500093);
    check1("fetch_c3_stall", stall_i_o, 1'b0);
    i_req_i = 0;
    @(negedge clk);
    #1 check1("fetch_c4_done", i_done_o, 1'b0);
    check32("fetch_c4_rdata_held", i_rdata_o, 32'h00500093);
    mem_gnt_i = 0;

    // Store held off by three cycles without grant.
    @(negedge clk);
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h3000; d_wdata_i = 32'hDEADBEEF; d_be_i = 4'b0011;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) mem_gnt_i = 1;
      #1 check1("store_memreq", mem_req_o, 1'b1);
      check1("store_we", mem_we_o, 1'b1);
      check32("store_addr", mem_addr_o, 32'h3000);
      check32("store_wdata", mem_wdata_o, 32'hDEADBEEF);
      check32("store_be", {28'h0, mem_be_o}, 32'h3);
    end
    @(negedge clk);
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
    #1 check1("store_wait_memreq", mem_req_o, 1'b0);
    check1("store_wait_done", d_done_o, 1'b0);
    @(negedge clk);
    mem_rvalid_i = 0;
    #1 check1("store_done", d_done_o, 1'b1);
    check32("store_rdata_captured", d_rdata_o, 32'hCAFEF00D);
    check1("store_done_stall", stall_d_o, 1'b0);
    check1("store_no_idone", i_done_o, 1'b0);
    d_req_i = 0;
    @(negedge clk);
    #1 check1("store_done_once", d_done_o, 1'b0);

    // Kill while the fetch is waiting on memory; a pending load follows.
    @(negedge clk);
    i_req_i = 1; i_addr_i = 32'h200; mem_gnt_i = 1;
    @(negedge clk);
    #1 check1("kill_req_phase", mem_req_o, 1'b1);
    check32("kill_req_addr", mem_addr_o, 32'h200);
    @(negedge clk);
    mem_gnt_i = 0; i_kill_i = 1;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h2000;
    #1 check1("kill_stall_i", stall_i_o, 1'b0);
    @(negedge clk);
    i_kill_i = 0; i_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11111111;
    @(negedge clk);
    mem_rvalid_i = 0;
    #1 check1("kill_no_done", i_done_o, 1'b0);
    check1("kill_idle_memreq", mem_req_o, 1'b0);
    check32("kill_rdata_unchanged", i_rdata_o, 32'h00500093);
    @(negedge clk);
    mem_gnt_i = 1;
    #1 check1("kill_d_launch", mem_req_o, 1'b1);
    check32("kill_d_addr", mem_addr_o, 32'h2000);
    check32("kill_d_be", {28'h0, mem_be_o}, 32'hF);
    check1("kill_no_done2", i_done_o, 1'b0);
    @(negedge clk);
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h22222222;
    @(negedge clk);
    mem_rvalid_i = 0;
    #1 check1("kill_d_done", d_done_o, 1'b1);
    check32("kill_d_rdata", d_rdata_o, 32'h22222222);
    d_req_i = 0;
    @(negedge clk);

    // Both sides held high: D wins four times, then I is forced through.
    @(negedge clk);
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1234;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h2004;
    i_req_i = 1; i_addr_i = 32'h104;
    for (int c = 0; c < 120 && got.size() < 10; c++) begin
      @(negedge clk);
      if (d_done_o) got.push_back(1'b1);
      if (i_done_o) got.push_back(1'b0);
    end
    i_req_i = 0; d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    if (got.size() < 10) fail_now("arb_order_timeout");
    for (int k = 0; k < got.size(); k++) begin
      check1($sformatf("arb_order_%0d_is_d", k), got[k], (k % 5) != 4);
    end
    repeat (2) @(negedge clk);

    // Reset while waiting; the late response must be ignored.
    @(negedge clk);
    i_req_i = 1; i_addr_i = 32'h108; mem_gnt_i = 1;
    @(negedge clk);
    @(negedge clk);
    mem_gnt_i = 0; rst = 1; i_req_i = 0;
    #1 quiet_checks("midrst");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    mem_rvalid_i = 1; mem_rdata_i = 32'h33333333;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_rvalid_i = 0;
      #1 check1("late_rvalid_no_idone", i_done_o, 1'b0);
      check1("late_rvalid_no_ddone", d_done_o, 1'b0);
      check1("late_rvalid_no_memreq", mem_req_o, 1'b0);
      check32("late_rvalid_irdata", i_rdata_o, 32'h0);
    end

    // Random traffic from both sides.
    fork
      begin
        fork
          i_driver(40);
          d_driver(40);
        join
        repeat (10) @(negedge clk);
        run_done = 1;
      end
      mem_model();
      monitor();
    join
    check32("i_queue_drained", 32'(i_exp_q.size()), 32'h0);
    check32("d_queue_drained", 32'(d_exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (I-side) and the load/store requester (D-side) of the 5-stage pipeline.
- Sequences one outstanding memory transaction at a time.
- Returns the read data and a one-cycle done pulse to the requester.
- Drives per-side stall outputs into the hazard unit.
- Default arbitration is data-priority, with a starvation guard for fetch.

Parameters:
DATA_WIDTH, 32, width of address, write data and read data
STARVE_LIMIT, 4, number of consecutive D-side wins while I-side is pending before I-side is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
i_req_i  in  1  fetch request; held with i_addr_i stable until i_done_o or i_kill_i
i_addr_i  in  DATA_WIDTH  fetch byte address
i_kill_i  in  1  fetch request cancelled (branch taken); one-cycle pulse
i_rdata_o  out  DATA_WIDTH  fetched word; valid while i_done_o=1
i_done_o  out  1  one-cycle completion pulse for fetch
d_req_i  in  1  data request; held with all d_* inputs stable until d_done_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  DATA_WIDTH  data byte address
d_wdata_i  in  DATA_WIDTH  store data
d_be_i  in  4  store byte enables
d_rdata_o  out  DATA_WIDTH  load word; valid while d_done_o=1
d_done_o  out  1  one-cycle completion pulse for data (loads and stores)
mem_req_o  out  1  request to memory
mem_we_o  out  1  write enable to memory
mem_addr_o  out  DATA_WIDTH  address to memory
mem_wdata_o  out  DATA_WIDTH  write data to memory
mem_be_o  out  4  byte enables to memory; 4'hF for fetch and loads
mem_gnt_i  in  1  memory accepts request this cycle
mem_rvalid_i  in  1  memory response valid (loads, fetches and stores)
mem_rdata_i  in  DATA_WIDTH  memory read data
stall_i_o  out  1  i_req_i & ~i_done_o & ~i_kill_i
stall_d_o  out  1  d_req_i & ~d_done_o

Behaviour:
- Reset values:
  - State IDLE, owner none, starve counter 0, kill flag 0.
  - All outputs 0, including rdata registers.
  - Reset mid-transaction abandons it; a late mem_rvalid_i seen in IDLE is ignored.
- Transaction order:
  - Requests are launched from IDLE only.
  - Exactly one transaction is outstanding at a time; no pipelining of requests.
- States:
  - IDLE:
    - Sample requests.
    - If d_req_i and i_req_i are both high: D wins unless starve counter == STARVE_LIMIT, in which case I wins.
    - If only one side requests, that side wins.
    - Record the owner and latch its request fields into registers.
    - Go to REQ.
  - REQ:
    - mem_req_o=1; mem_* outputs come from the latched fields.
    - Stay in REQ until mem_gnt_i=1, then go to WAIT.
  - WAIT:
    - mem_req_o=0.
    - On mem_rvalid_i, capture mem_rdata_i into the owner's rdata register and go to DONE.
  - DONE:
    - Pulse the owner's done output for exactly one cycle, then go to IDLE.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when D wins in IDLE while i_req_i=1.
  - Clears when I wins.
  - Unchanged otherwise.
- Re-requests:
  - A requester that still holds req in the cycle after its done pulse issues a new request.
  - The IDLE cycle after DONE is a mandatory bubble.
- Latency: with memory granting immediately and responding the cycle after grant, request at cycle c0 gives mem_req_o at c1, rvalid at c2, done at c3.
- Kill:
  - i_kill_i in IDLE or in the same cycle I-side would win: I is not selected that cycle.
  - i_kill_i while I owns the port (REQ/WAIT):
    - Set the kill flag; the transaction still completes on the memory side.
    - No i_done_o pulse; i_rdata_o is unchanged.
    - FSM returns WAIT -> IDLE directly on mem_rvalid_i.
  - i_kill_i is ignored when D owns the port.
- Stores return mem_rvalid_i like loads; d_rdata_o is undefined-but-captured for stores (it takes mem_rdata_i).
- i_done_o and d_done_o are never asserted in the same cycle.

Test Plan:
- Single fetch:
  - Stimulus: i_req_i=1, addr 0x100; memory grants immediately and returns 0x00500093 one cycle later.
  - Response: mem_req_o at c1 with mem_addr_o=0x100, mem_be_o=4'hF; i_done_o at c3 with i_rdata_o=0x00500093; stall_i_o=1 during c0-c2.
- Simultaneous requests:
  - Stimulus: I (0x104) and D load (0x2000) both requested in the same cycle.
  - Response: D is served first (d_done_o, then IDLE bubble), then I; starve counter reads 1 after D wins and 0 after I wins.
- Starvation:
  - Stimulus: D requests continuously with I pending, STARVE_LIMIT=4.
  - Response: four D transactions, then I wins the fifth arbitration even though d_req_i=1.
- Kill:
  - Stimulus: i_kill_i pulses while in WAIT on an I transaction.
  - Response: no i_done_o pulse; FSM reaches IDLE the cycle after mem_rvalid_i; a pending D request launches next.
- Store with back-pressure:
  - Stimulus: d_we_i=1, addr 0x3000, wdata 0xDEADBEEF, be 4'b0011; mem_gnt_i is held low for 3 cycles.
  - Response: mem_req_o held high with stable fields for 4 cycles; d_done_o pulses once after rvalid.
- Reset mid-transaction:
  - Stimulus: rst asserted in WAIT, then rvalid arrives after release.
  - Response: all outputs 0 immediately; no done pulses; the late rvalid is ignored.
